trafficgen_stream_core: RTL and testbench
=========================================

// Module: trafficgen_stream_core
// PURPOSE
//  Traffic engine sitting directly downstream of the trafficgen AXI4-Lite register slave (S00_AXI).
//  Consumes the decoded control registers (CTRL/SEED/LEN) and emits a programmed-length burst of
//  pattern data on an AXI4-Stream master port. Reports busy/done/beat count back for the STATUS register.
// PARAMETERS
//  DATA_W  32  AXIS tdata width and pattern width (matches S00_AXI register width)
//  LEN_W   16  beat-count width; max burst = 2^LEN_W-1 beats
// PORTS
//  ACLK           in   1       single clock for the block
//  ARESET         in   1       asynchronous, active-high reset
//  cfg_start      in   1       one-cycle pulse (CTRL bit0 write) - launch burst
//  cfg_abort      in   1       one-cycle pulse (CTRL bit1 write) - end burst early
//  cfg_seed       in   DATA_W  first data word of the burst (SEED reg)
//  cfg_len        in   LEN_W   number of beats to send (LEN reg)
//  sts_busy       out  1       burst in progress
//  sts_done       out  1       sticky: last burst completed; cleared by next accepted start
//  sts_aborted    out  1       sticky: last burst ended by abort; cleared by next accepted start
//  sts_beats      out  LEN_W   beats handshaken in current/last burst
//  m_axis_tdata   out  DATA_W  pattern word
//  m_axis_tvalid  out  1       AXIS valid
//  m_axis_tready  in   1       AXIS ready
//  m_axis_tlast   out  1       high on final beat of burst
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE; all outputs 0; pattern/len regs 0.
//  - FSM IDLE -> RUN -> DONE. DONE behaves as IDLE for start (accepts a new start).
//  - start in IDLE/DONE: latch seed, len; clear done/aborted/beats. len!=0 -> RUN, tvalid=1 next cycle
//    (1-cycle latency). len==0 -> DONE next cycle, done=1, no tvalid ever asserted.
//  - start while RUN: ignored. start and abort in same cycle in IDLE/DONE: start wins, abort dropped.
//  - RUN: tvalid=1, busy=1. Handshake = tvalid&tready. tdata/tlast held stable while tready=0.
//  - Per handshake: beats+1; pattern advances (incrementing: +1 mod 2^DATA_W, wrap 0xFFFFFFFF->0).
//  - tlast=1 when beats==len-1 or abort pending. Handshake with tlast -> DONE next cycle:
//    tvalid=0, busy=0, done=1.
//  - abort in RUN: sets abort_pending; tvalid never drops mid-beat (AXIS rule); current beat is
//    re-flagged tlast=1 (permitted only because tdata unchanged) and on its handshake -> DONE with
//    done=1, aborted=1. Abort arriving on the natural last beat: aborted=1 as well. abort in IDLE/DONE: ignored.
//  - Reset mid-burst: tvalid drops immediately (async), partial burst discarded, state IDLE.
//  - sts_beats saturates-free: bounded by len, never wraps.
// CONFIGURATION
//  TRAFFICGEN_PRBS_EN defined: pattern advances by 32-bit Galois LFSR, poly x^32+x^22+x^2+x+1
//    (taps 0x80200003), first beat = seed; seed==0 forced to 1 at latch (LFSR lock-up avoided).
//  Undefined: incrementing pattern only; no LFSR logic synthesised. Port list identical in both.
// STRUCTURE
//  - Package trafficgen_pkg: state enum (ST_IDLE, ST_RUN, ST_DONE), LFSR_POLY constant,
//    CTRL bit indices (CTRL_START_BIT=0, CTRL_ABORT_BIT=1), STATUS bit layout shared with S00_AXI.
//  - One sub-module trafficgen_pattern_gen: holds pattern reg, load(seed)/step inputs, selects
//    increment vs LFSR under TRAFFICGEN_PRBS_EN. FSM, counter, AXIS regs in top.
// TESTING
//  1 seed=0x00000001 len=4 tready=1 -> tdata 1,2,3,4; tlast on 4th only; done=1 busy=0 beats=4.
//  2 same cfg, tready random 50% -> identical data/tlast order; tdata/tlast stable on stalls.
//  3 len=0 start -> tvalid never high; done=1 one cycle after start; beats=0.
//  4 seed=0xFFFFFFFE len=3 -> 0xFFFFFFFE,0xFFFFFFFF,0x00000000 (wrap); second start mid-burst ignored.
//  5 len=10, abort after 2 beats with tready=0 -> beat 3 (tdata=seed+2) tlast=1; done=1 aborted=1 beats=3.
//  6 ARESET pulse mid-burst -> tvalid/busy 0 same cycle; restart seed=5 len=2 -> 5,6 cleanly.
//    (PRBS build: seed=0 len=2 -> 0x00000001 then 0x80200003.)

Source files
------------

// File: rtl/trafficgen_pkg.sv
// Shared definitions for the trafficgen stream engine and its AXI4-Lite register slave.
// Optional PRBS pattern mode is selected by the TRAFFICGEN_PRBS_EN macro.
package trafficgen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;

  localparam int STS_BUSY_BIT    = 0;
  localparam int STS_DONE_BIT    = 1;
  localparam int STS_ABORTED_BIT = 2;
  localparam int STS_BEATS_LSB   = 16;

endpackage

// File: rtl/trafficgen_pattern_gen.sv
// Pattern register for the stream engine: incrementing counter, or a Galois LFSR when
// TRAFFICGEN_PRBS_EN is defined.
module trafficgen_pattern_gen
  import trafficgen_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] pattern
);

  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] next_val;

`ifdef TRAFFICGEN_PRBS_EN
  // An all-zero LFSR state never leaves zero, so a zero seed is promoted to 1.
  always_comb begin
    load_val = (seed == '0) ? DATA_W'(1) : seed;
    next_val = (pattern >> 1) ^ (pattern[0] ? DATA_W'(LFSR_POLY) : '0);
  end
`else
  always_comb begin
    load_val = seed;
    next_val = pattern + DATA_W'(1);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pattern <= '0;
    else if (load) pattern <= load_val;
    else if (step) pattern <= next_val;
  end

endmodule

// File: rtl/trafficgen_stream_core.sv
// Burst engine: turns CTRL/SEED/LEN register writes into an AXI4-Stream burst of pattern data.
// Pattern source selected by TRAFFICGEN_PRBS_EN (incrementing when undefined).
module trafficgen_stream_core
  import trafficgen_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [DATA_W-1:0] cfg_seed,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              sts_busy,
  output logic              sts_done,
  output logic              sts_aborted,
  output logic [LEN_W-1:0]  sts_beats,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast
);

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q;
  logic             abort_pend;
  logic             accept;
  logic             hs;
  logic             last_beat;

  assign accept    = cfg_start && (state != ST_RUN);
  assign hs        = m_axis_tvalid && m_axis_tready;
  assign last_beat = (sts_beats == len_q - LEN_W'(1));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (accept) state_nxt = (cfg_len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:           if (hs && m_axis_tlast) state_nxt = ST_DONE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // Abort only re-flags the beat already on the bus, so tdata never changes under a stall.
  always_comb begin
    m_axis_tvalid = (state == ST_RUN);
    sts_busy      = (state == ST_RUN);
    m_axis_tlast  = (state == ST_RUN) && (last_beat || abort_pend);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      len_q       <= '0;
      sts_beats   <= '0;
      abort_pend  <= 1'b0;
      sts_done    <= 1'b0;
      sts_aborted <= 1'b0;
    end else if (accept) begin
      len_q       <= cfg_len;
      sts_beats   <= '0;
      abort_pend  <= 1'b0;
      sts_aborted <= 1'b0;
      sts_done    <= (cfg_len == '0);
    end else if (state == ST_RUN) begin
      if (cfg_abort) abort_pend <= 1'b1;
      if (hs) begin
        sts_beats <= sts_beats + LEN_W'(1);
        if (m_axis_tlast) begin
          sts_done    <= 1'b1;
          sts_aborted <= abort_pend || cfg_abort;
        end
      end
    end
  end

  trafficgen_pattern_gen #(.DATA_W(DATA_W)) u_pattern (
    .clk     (ACLK),
    .rst     (ARESET),
    .load    (accept),
    .step    (hs),
    .seed    (cfg_seed),
    .pattern (m_axis_tdata)
  );

endmodule

// File: tb/tb_trafficgen_stream_core.sv
// Directed + randomized bench for trafficgen_stream_core against a beat-list reference model.
module tb_trafficgen_stream_core;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cfg_start, cfg_abort;
  logic [31:0] cfg_seed;
  logic [15:0] cfg_len;
  logic        sts_busy, sts_done, sts_aborted;
  logic [15:0] sts_beats;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;

  int vectors = 0;
  int miscompares = 0;

  always #5 ACLK = ~ACLK;

  trafficgen_stream_core #(.DATA_W(32), .LEN_W(16)) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .cfg_start     (cfg_start),
    .cfg_abort     (cfg_abort),
    .cfg_seed      (cfg_seed),
    .cfg_len       (cfg_len),
    .sts_busy      (sts_busy),
    .sts_done      (sts_done),
    .sts_aborted   (sts_aborted),
    .sts_beats     (sts_beats),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  // Reference pattern sequence: word k of a burst.
  function automatic logic [31:0] first_word(input logic [31:0] s);
`ifdef TRAFFICGEN_PRBS_EN
    return (s == 32'd0) ? 32'd1 : s;
`else
    return s;
`endif
  endfunction

  function automatic logic [31:0] next_word(input logic [31:0] w);
`ifdef TRAFFICGEN_PRBS_EN
    return w[0] ? ((w >> 1) ^ 32'h8020_0003) : (w >> 1);
`else
    return w + 32'd1;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One burst. abort_at>=0 pulses abort once that many beats have been accepted;
  // the model then expects exactly one more beat (or the natural end, if sooner).
  task automatic run_burst(input logic [31:0] seed, input logic [15:0] len, input int rdy_pct,
                           input int abort_at, input bit abort_stall, input bit poke_start,
                           input bit abort_with_start);
    logic [31:0] exp_d;
    int hs, total;
    bit aborting, poked;
    hs = 0; total = int'(len); aborting = 0; poked = 0;
    exp_d = first_word(seed);
    @(negedge ACLK);
    cfg_start = 1'b1; cfg_abort = abort_with_start; cfg_seed = seed; cfg_len = len;
    m_axis_tready = 1'b0;
    @(negedge ACLK);
    cfg_start = 1'b0; cfg_abort = 1'b0;
    #2;
    if (len == 16'd0) begin
      check("len0_done", sts_done, 1);
      check("len0_tvalid", m_axis_tvalid, 0);
      check("len0_beats", sts_beats, 0);
      check("len0_busy", sts_busy, 0);
      repeat (3) begin
        @(negedge ACLK); #2;
        check("len0_tvalid_later", m_axis_tvalid, 0);
      end
      return;
    end
    check("start_busy", sts_busy, 1);
    check("start_done_clr", sts_done, 0);
    check("start_aborted_clr", sts_aborted, 0);
    for (int cyc = 0; cyc < 2000 && hs < total; cyc++) begin
      @(negedge ACLK);
      cfg_start = 1'b0; cfg_abort = 1'b0;
      m_axis_tready = ($urandom_range(99) < rdy_pct);
      if (abort_at >= 0 && !aborting && hs >= abort_at) begin
        cfg_abort = 1'b1;
        if (abort_stall) m_axis_tready = 1'b0;
      end
      if (poke_start && !poked && hs == 1) begin
        cfg_start = 1'b1; cfg_seed = 32'h1234_5678; cfg_len = 16'd7; poked = 1;
      end
      #2;
      check("tvalid", m_axis_tvalid, 1);
      check("tdata", m_axis_tdata, exp_d);
      check("tlast", m_axis_tlast, (hs == total - 1));
      check("beats_run", sts_beats, hs);
      if (cfg_abort) begin
        aborting = 1;
        total = (hs + int'(m_axis_tready) + 1 < int'(len)) ? hs + int'(m_axis_tready) + 1 : int'(len);
      end
      if (m_axis_tready) begin
        hs++;
        exp_d = next_word(exp_d);
      end
    end
    @(negedge ACLK);
    cfg_start = 1'b0; cfg_abort = 1'b0; m_axis_tready = 1'b0;
    #2;
    check("burst_complete", hs, total);
    check("end_tvalid", m_axis_tvalid, 0);
    check("end_busy", sts_busy, 0);
    check("end_done", sts_done, 1);
    check("end_aborted", sts_aborted, aborting);
    check("end_beats", sts_beats, total);
  endtask

  initial begin
    ARESET = 1'b1; cfg_start = 0; cfg_abort = 0; cfg_seed = 0; cfg_len = 0; m_axis_tready = 0;
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_busy", sts_busy, 0);
    check("rst_done", sts_done, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_beats", sts_beats, 0);
    check("rst_tlast", m_axis_tlast, 0);
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;

    run_burst(32'h0000_0001, 16'd4, 100, -1, 0, 0, 0);   // basic
    run_burst(32'h0000_0001, 16'd4, 50, -1, 0, 0, 0);    // random backpressure
    run_burst(32'h0000_0000, 16'd0, 100, -1, 0, 0, 0);   // zero length
    run_burst(32'hFFFF_FFFE, 16'd3, 100, -1, 0, 1, 0);   // wrap + ignored restart
    run_burst(32'h0000_0100, 16'd10, 100, 2, 1, 0, 0);   // abort on stalled beat
    run_burst(32'h0000_0200, 16'd4, 100, 3, 0, 0, 0);    // abort on natural last beat
    run_burst(32'h0000_0300, 16'd5, 100, -1, 0, 0, 1);   // start beats same-cycle abort

    // abort while DONE is ignored
    @(negedge ACLK); cfg_abort = 1'b1;
    @(negedge ACLK); cfg_abort = 1'b0; #2;
    check("idle_abort_done", sts_done, 1);
    check("idle_abort_aborted", sts_aborted, 0);
    check("idle_abort_tvalid", m_axis_tvalid, 0);

    for (int i = 0; i < 6; i++)
      run_burst($urandom, 16'($urandom_range(1, 12)), 60,
                ($urandom_range(1) != 0) ? int'($urandom_range(0, 8)) : -1, 0, 0, 0);

    // reset mid-burst
    @(negedge ACLK);
    cfg_start = 1'b1; cfg_seed = 32'h0000_0040; cfg_len = 16'd10; m_axis_tready = 1'b1;
    @(negedge ACLK); cfg_start = 1'b0;
    repeat (2) @(negedge ACLK);
    #1;
    check("pre_rst_tvalid", m_axis_tvalid, 1);
    ARESET = 1'b1;
    #1;
    check("async_rst_tvalid", m_axis_tvalid, 0);
    check("async_rst_busy", sts_busy, 0);
    check("async_rst_beats", sts_beats, 0);
    check("async_rst_tdata", m_axis_tdata, 0);
    @(negedge ACLK); ARESET = 1'b0; m_axis_tready = 1'b0;
`ifdef TRAFFICGEN_PRBS_EN
    run_burst(32'h0000_0000, 16'd2, 100, -1, 0, 0, 0);
`else
    run_burst(32'h0000_0005, 16'd2, 100, -1, 0, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
